// File: rtl/uart_tx_arbiter.sv
// Two-requester byte arbiter feeding a UART transmitter, with per-frame channel locking.
// Optional frame XOR checksum byte is compiled in when UART_TX_ARB_XOR_CHK_EN is defined.
module uart_tx_arbiter #(
  parameter int unsigned ACK_TIMEOUT = 32'd16
) (
  input  logic            CLK_i,
  input  logic            Reset_i,
  input  logic [1:0]      req_valid_i,
  input  logic [1:0][7:0] req_data_i,
  input  logic [1:0]      req_last_i,
  output logic [1:0]      req_ready_o,
  output logic [7:0]      tx_data_o,
  output logic            tx_data_ready_o,
  input  logic            tx_ready_to_send_i,
  output logic [1:0]      grant_o,
  output logic            busy_o,
  output logic            err_timeout_o
);

`ifdef UART_TX_ARB_XOR_CHK_EN
  typedef enum logic [2:0] {IDLE, STROBE, WAIT_ACK, WAIT_DONE, CHK} state_t;
`else
  typedef enum logic [1:0] {IDLE, STROBE, WAIT_ACK, WAIT_DONE} state_t;
`endif

  // The strobe cycle itself counts toward the timeout, so WAIT_ACK stops one short.
  localparam logic [31:0] ACK_LIMIT = (ACK_TIMEOUT > 32'd0) ? ACK_TIMEOUT - 32'd1 : 32'd0;

  state_t      state;
  logic        lock;
  logic        last_grant;
  logic        frame_last;
  logic [31:0] ack_cnt;
  logic        sel;
  logic        fire;
`ifdef UART_TX_ARB_XOR_CHK_EN
  logic [7:0]  chk_acc;
  logic        chk_phase;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sel = ~last_grant;
    if (lock)
      sel = grant_o[1];
    else if (req_valid_i == 2'b01)
      sel = 1'b0;
    else if (req_valid_i == 2'b10)
      sel = 1'b1;
    req_ready_o = 2'b00;
    if (state == IDLE && tx_ready_to_send_i)
      req_ready_o[sel] = 1'b1;
  end

  assign fire   = |(req_ready_o & req_valid_i);
  assign busy_o = (state != IDLE) || lock;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK_i or negedge Reset_i) begin
    if (!Reset_i) begin
      state           <= IDLE;
      tx_data_o       <= 8'h00;
      tx_data_ready_o <= 1'b0;
      grant_o         <= 2'b00;
      err_timeout_o   <= 1'b0;
      lock            <= 1'b0;
      last_grant      <= 1'b1;
      frame_last      <= 1'b0;
      ack_cnt         <= 32'd0;
`ifdef UART_TX_ARB_XOR_CHK_EN
      chk_acc         <= 8'h00;
      chk_phase       <= 1'b0;
`endif
    end else begin
      tx_data_ready_o <= 1'b0;
      case (state)
        IDLE: begin
          if (fire) begin
            tx_data_o       <= req_data_i[sel];
            tx_data_ready_o <= 1'b1;
            grant_o         <= sel ? 2'b10 : 2'b01;
            lock            <= 1'b1;
            frame_last      <= req_last_i[sel];
`ifdef UART_TX_ARB_XOR_CHK_EN
            chk_acc         <= chk_acc ^ req_data_i[sel];
`endif
            state           <= STROBE;
          end
        end
        STROBE: begin
          ack_cnt <= 32'd1;
          state   <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (!tx_ready_to_send_i) begin
            state <= WAIT_DONE;
          end else if (ack_cnt >= ACK_LIMIT) begin
            err_timeout_o <= 1'b1;
            lock          <= 1'b0;
            grant_o       <= 2'b00;
`ifdef UART_TX_ARB_XOR_CHK_EN
            chk_acc       <= 8'h00;
            chk_phase     <= 1'b0;
`endif
            state         <= IDLE;
          end else begin
            ack_cnt <= ack_cnt + 32'd1;
          end
        end
        WAIT_DONE: begin
          if (tx_ready_to_send_i) begin
            if (!frame_last) begin
              state <= IDLE;
`ifdef UART_TX_ARB_XOR_CHK_EN
            end else if (!chk_phase) begin
              state <= CHK;
`endif
            end else begin
              lock       <= 1'b0;
              grant_o    <= 2'b00;
              last_grant <= grant_o[1];
`ifdef UART_TX_ARB_XOR_CHK_EN
              chk_acc    <= 8'h00;
              chk_phase  <= 1'b0;
`endif
              state      <= IDLE;
            end
          end
        end
`ifdef UART_TX_ARB_XOR_CHK_EN
        CHK: begin
          tx_data_o       <= chk_acc;
          tx_data_ready_o <= 1'b1;
          chk_phase       <= 1'b1;
          state           <= STROBE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized self-checking bench for uart_tx_arbiter: frame-level arbitration model,
// transmitter model, strobe scoreboard, plus timeout and mid-frame reset scenarios.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int unsigned TIMEOUT = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      req_valid;
  logic [1:0][7:0] req_data;
  logic [1:0]      req_last;
  logic [1:0]      req_ready;
  logic [7:0]      tx_data;
  logic            tx_strobe;
  logic            tx_rts;
  logic [1:0]      grant;
  logic            busy;
  logic            err;

  uart_tx_arbiter #(.ACK_TIMEOUT(TIMEOUT)) dut (
    .CLK_i(clk), .Reset_i(rst_n),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
    .req_ready_o(req_ready), .tx_data_o(tx_data), .tx_data_ready_o(tx_strobe),
    .tx_ready_to_send_i(tx_rts), .grant_o(grant), .busy_o(busy), .err_timeout_o(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Requester byte entry: {gap cycles before offering, last, data}.
  typedef logic [12:0] entry_t;
  typedef struct {
    int          ch;
    int          len;
    logic [31:0] b;
  } frame_t;

  entry_t     q0[$], q1[$];
  int         wait0, wait1;
  frame_t     pend0[$], pend1[$];
  int         exp_ch[$];
  logic [7:0] exp_byte[$];
  int         exp_own[$];
  int         mdl_last;

  int         tx_mode;  // 0 responsive, 1 never acknowledges, 2 acknowledges but never finishes
  bit         tx_pending;
  int         drop_wait, busy_left;

  int         cyc, strobe_cyc, err_cyc;
  bit         err_seen, prev_strobe;
  logic [7:0] held_data;

  task automatic drive();
    req_valid = 2'b00;
    req_data  = '0;
    req_last  = 2'b00;
    if (q0.size() > 0) begin
      req_data[0]  = q0[0][7:0];
      req_last[0]  = q0[0][8];
      req_valid[0] = (wait0 >= int'(q0[0][12:9]));
    end
    if (q1.size() > 0) begin
      req_data[1]  = q1[0][7:0];
      req_last[1]  = q1[0][8];
      req_valid[1] = (wait1 >= int'(q1[0][12:9]));
    end
  endtask

  task automatic add_frame(input int ch, input int len, input logic [31:0] bytes,
                           input logic [15:0] gaps);
    frame_t f;
    entry_t e;
    f.ch = ch; f.len = len; f.b = bytes;
    for (int i = 0; i < len; i++) begin
      e = {gaps[4*i +: 4], (i == len - 1), bytes[8*i +: 8]};
      if (ch == 0) q0.push_back(e); else q1.push_back(e);
    end
    if (ch == 0) pend0.push_back(f); else pend1.push_back(f);
    drive();
  endtask

  // Frames are atomic; on a tie the channel not served last goes next.
  task automatic plan();
    frame_t f;
    int c;
    while (pend0.size() > 0 || pend1.size() > 0) begin
      if (pend0.size() > 0 && pend1.size() > 0) c = 1 - mdl_last;
      else c = (pend0.size() > 0) ? 0 : 1;
      if (c == 0) f = pend0.pop_front(); else f = pend1.pop_front();
      for (int i = 0; i < f.len; i++) begin
        exp_ch.push_back(c);
        exp_byte.push_back(f.b[8*i +: 8]);
        exp_own.push_back(c);
      end
`ifdef UART_TX_ARB_XOR_CHK_EN
      begin
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < f.len; i++) acc = acc ^ f.b[8*i +: 8];
        exp_byte.push_back(acc);
        exp_own.push_back(c);
      end
`endif
      mdl_last = c;
    end
  endtask

  task automatic step();
    logic [1:0] hs;
    @(negedge clk);
    cyc++;
    hs = req_valid & req_ready;
    for (int c = 0; c < 2; c++) begin
      if (hs[c]) begin
        if (exp_ch.size() == 0) check("accept_extra", 32'(c), 32'hFF);
        else begin
          check("accept_ch", 32'(c), 32'(exp_ch[0]));
          void'(exp_ch.pop_front());
        end
      end
    end
    if (tx_strobe) begin
      if (prev_strobe) check("strobe_width", 32'd2, 32'd1);
      if (exp_byte.size() == 0) check("strobe_extra", 32'(tx_data), 32'h100);
      else begin
        check("strobe_data", 32'(tx_data), 32'(exp_byte[0]));
        check("strobe_grant", 32'(grant), 32'd1 << exp_own[0]);
        check("strobe_busy", 32'(busy), 32'd1);
        void'(exp_byte.pop_front());
        void'(exp_own.pop_front());
      end
      held_data  = tx_data;
      strobe_cyc = cyc;
      tx_pending = 1'b1;
      drop_wait  = $urandom_range(0, 2);
      busy_left  = $urandom_range(1, 3);
    end else begin
      check("data_hold", 32'(tx_data), 32'(held_data));
    end
    prev_strobe = tx_strobe;
    if (err && !err_seen) begin
      err_seen = 1'b1;
      err_cyc  = cyc;
    end
    @(posedge clk);
    #1;
    if (hs[0]) begin void'(q0.pop_front()); wait0 = 0; end
    else if (q0.size() > 0) wait0++;
    if (hs[1]) begin void'(q1.pop_front()); wait1 = 0; end
    else if (q1.size() > 0) wait1++;
    case (tx_mode)
      1: tx_rts = 1'b1;
      2: tx_rts = !tx_pending;
      default: begin
        if (!tx_pending) tx_rts = 1'b1;
        else if (drop_wait > 0) begin drop_wait--; tx_rts = 1'b1; end
        else if (busy_left > 0) begin busy_left--; tx_rts = 1'b0; end
        else begin tx_rts = 1'b1; tx_pending = 1'b0; end
      end
    endcase
    drive();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_byte.size() > 0 || exp_ch.size() > 0 || q0.size() > 0 || q1.size() > 0)
           && n < 2000) begin
      step();
      n++;
    end
    check({tag, "_drained"}, 32'(n < 2000), 32'd1);
    n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_grant"}, 32'(grant), 32'd0);
  endtask

  task automatic clear_model();
    q0.delete(); q1.delete(); pend0.delete(); pend1.delete();
    exp_ch.delete(); exp_byte.delete(); exp_own.delete();
    wait0 = 0; wait1 = 0;
    tx_mode = 0; tx_pending = 1'b0; tx_rts = 1'b1;
    mdl_last = 1; held_data = 8'h00; prev_strobe = 1'b0;
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int nexp;
    rst_n = 1'b0;
    cyc = 0; strobe_cyc = 0; err_cyc = 0; err_seen = 1'b0;
    do_reset();

    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_strobe", 32'(tx_strobe), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // Single byte frame from ch0.
    add_frame(0, 1, 32'hA5, 16'h0);
    plan();
    drain("single");
    check("single_err", 32'(err), 32'd0);

    // Simultaneous requests after reset, then a second tie.
    do_reset();
    add_frame(0, 1, 32'h11, 16'h0);
    add_frame(1, 1, 32'h22, 16'h0);
    add_frame(0, 1, 32'h33, 16'h0);
    add_frame(1, 1, 32'h44, 16'h0);
    plan();
    drain("tie");

    // ch1 holds the lock across an idle gap while ch0 keeps offering.
    add_frame(0, 1, 32'h5A, 16'h0);
    plan();
    drain("prelock");
    add_frame(1, 2, 32'h0201, 16'h0030);
    add_frame(0, 1, 32'h77, 16'h0);
    plan();
    drain("lock");

    // Transmitter never acknowledges the strobe.
    tx_mode = 1;
    err_seen = 1'b0;
    q0.push_back({4'd0, 1'b1, 8'h55});
    exp_ch.push_back(0); exp_byte.push_back(8'h55); exp_own.push_back(0);
    drive();
    n = 0;
    while (!err_seen && n < 200) begin
      step();
      n++;
    end
    check("to_seen", 32'(err_seen), 32'd1);
    check("to_cycles", 32'(err_cyc - strobe_cyc), TIMEOUT);
    check("to_busy", 32'(busy), 32'd0);
    check("to_grant", 32'(grant), 32'd0);
    tx_mode = 0; tx_pending = 1'b0; tx_rts = 1'b1;
    add_frame(1, 1, 32'h66, 16'h0);
    plan();
    drain("after_to");
    check("to_sticky", 32'(err), 32'd1);

    // Two-byte frame; checksum byte follows when compiled in.
    add_frame(0, 2, 32'h0F3C, 16'h0);
    plan();
    drain("chk");

    // Random frames from both channels, gaps only inside a frame.
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 2; c++) begin
        int nf;
        nf = $urandom_range(1, 3);
        for (int f = 0; f < nf; f++)
          add_frame(c, $urandom_range(1, 4), $urandom, 16'($urandom) & 16'h3330);
      end
      plan();
      drain("rand");
    end

    // Reset pulsed while a locked frame sits in WAIT_DONE.
    tx_mode = 2;
    add_frame(0, 2, 32'hA1A0, 16'h0);
    plan();
    nexp = exp_byte.size();
    n = 0;
    while (exp_byte.size() == nexp && n < 50) begin
      step();
      n++;
    end
    repeat (3) step();
    check("pre_rst_busy", 32'(busy), 32'd1);
    check("pre_rst_grant", 32'(grant), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx_data", 32'(tx_data), 32'h00);
    check("mid_rst_strobe", 32'(tx_strobe), 32'd0);
    check("mid_rst_grant", 32'(grant), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (6) step();
    check("post_rst_quiet", 32'(busy), 32'd0);
    add_frame(1, 1, 32'h77, 16'h0);
    plan();
    drain("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 32'd16: clock cycles allowed for the transmitter to drop tx_ready_to_send_i after a strobe.
REQ-002 SHALL have port CLK_i  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port Reset_i  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports req_valid_i[k]  input  1 / req_data_i[k]  input  8 / req_last_i[k]  input  1  for requesters k=0,1: byte offer, byte value, final byte of frame.
REQ-005 SHALL have port req_ready_o  output  2  per-requester accept; a byte transfers when valid and ready are both high in one cycle.
REQ-006 SHALL have ports tx_data_o  output  8  and tx_data_ready_o  output  1  toward the Transmitter (data, one-cycle load strobe).
REQ-007 SHALL have port tx_ready_to_send_i  input  1  Transmitter idle indication.
REQ-008 SHALL have ports grant_o  output  2  (one-hot current owner, 0 when none), busy_o  output  1, err_timeout_o  output  1  (sticky).

Function
REQ-009 SHALL implement states IDLE, STROBE, WAIT_ACK, WAIT_DONE, plus CHK when the checksum feature is compiled in.
REQ-010 SHALL, in IDLE with tx_ready_to_send_i=1, drive req_ready_o combinationally high for exactly one selected channel and low for the other.
REQ-011 SHALL select the channel as follows: lock held -> owner only; one valid -> that channel; both valid -> the channel not granted last.
REQ-012 SHALL, on transfer in cycle N, latch the data, set the owner and enter STROBE; at N+1, drive tx_data_o with the byte and tx_data_ready_o=1 for that cycle only, then enter WAIT_ACK.
REQ-013 SHALL, in WAIT_ACK, go to WAIT_DONE on tx_ready_to_send_i=0, else count cycles.
REQ-014 SHALL, when ACK_TIMEOUT cycles elapse in WAIT_ACK, set err_timeout_o, clear the lock and owner, discard any pending checksum and return to IDLE.
REQ-015 SHALL, in WAIT_DONE on tx_ready_to_send_i=1, act as follows: if req_last_i was 0 on the byte -> IDLE with lock held; if 1 -> release the lock and record last grant (or go to CHK if compiled in).
REQ-016 SHALL, while a lock is held, ignore the other channel indefinitely even if the owner offers no byte.
REQ-017 SHALL hold tx_data_o stable from STROBE until the next strobe.
REQ-018 SHALL assert busy_o in every state except IDLE, and also in IDLE while a lock is held.
REQ-019 SHALL keep grant_o equal to the owner from transfer until lock release.

Reset
REQ-020 SHALL, on Reset_i=0 (asynchronous, including mid-frame), force: state IDLE; tx_data_ready_o=0; tx_data_o=8'h00; grant_o=2'b00; busy_o=0; err_timeout_o=0; lock cleared; checksum 8'h00; last grant = channel 1 (so channel 0 wins the first tie).
REQ-021 SHALL resume normal operation on the first rising CLK_i edge after Reset_i deasserts.

Configuration
REQ-022 SHALL compile the frame checksum in only when macro UART_TX_ARB_XOR_CHK_EN is defined.
REQ-023 SHALL, with UART_TX_ARB_XOR_CHK_EN defined: XOR every accepted byte of a frame into an 8-bit accumulator seeded 8'h00; after the last byte's WAIT_DONE, CHK loads the accumulator and sends it through STROBE/WAIT_ACK/WAIT_DONE; then release the lock and clear the accumulator.
REQ-024 SHALL, without the macro, have no CHK state and no accumulator; each frame releases the lock after its last data byte.

Verification
REQ-025 SHALL cover: ch0 sends 8'hA5 with last=1 while the Transmitter model is responsive -> one strobe with tx_data_o=8'hA5, grant_o=01 during the frame, then 00, busy_o low again.
REQ-026 SHALL cover: both channels valid simultaneously after reset (ch0 8'h11, ch1 8'h22, last=1) -> 8'h11 sent first, then 8'h22; a second tie is granted to ch0.
REQ-027 SHALL cover: ch1 frame 8'h01, 8'h02 (last on 8'h02) while ch0 is valid throughout -> ch0 req_ready_o stays 0 until ch1 releases; bytes sent in order 01, 02.
REQ-028 SHALL cover: tx_ready_to_send_i held at 1 after a strobe -> err_timeout_o=1 exactly ACK_TIMEOUT cycles later, state IDLE, lock cleared, next request accepted.
REQ-029 SHALL cover: with UART_TX_ARB_XOR_CHK_EN, frame 8'h3C, 8'h0F -> third strobe carries 8'h33; without the macro -> only two strobes.
REQ-030 SHALL cover: Reset_i pulsed low during WAIT_DONE of a locked frame -> all outputs reach reset values immediately, with no strobe until a new transfer occurs.
